// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared funct3 encodings, FSM states and the access size mask
package mem_port_arbiter_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_IF = 2'd1, WAIT_MEM = 2'd2} state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores, extension for loads, alignment check
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr,
  input  logic        store,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  we,
  output logic [63:0] wdata_rep,
  output logic [63:0] ldata,
  output logic        mis
);
  logic [1:0]  size;
  logic [2:0]  lo;
  logic [63:0] sh;
  logic        sx;
  assign size = funct3[1:0];
  // decode size, check alignment, steer store lanes and extend the selected load lane
  always_comb begin
    lo = size == 2'd0 ? 3'd0 : size == 2'd1 ? 3'd1 : size == 2'd2 ? 3'd3 : 3'd7;
    mis = (store ? funct3 > SD : funct3 > LWU) || (addr & lo) != 3'd0;
    we = mis ? 8'h00 : size_mask(size) << addr;
    wdata_rep = funct3 == SB ? {8{wdata[7:0]}} : funct3 == SH ? {4{wdata[15:0]}} :
                funct3 == SW ? {2{wdata[31:0]}} : wdata;
    sh = rdata >> {addr, 3'b000};
    sx = !(funct3 inside {LBU, LHU, LWU});
    ldata = mis ? 64'd0 :
            (funct3 == LB || funct3 == LBU) ? {{56{sx & sh[7]}}, sh[7:0]} :
            (funct3 == LH || funct3 == LHU) ? {{48{sx & sh[15]}}, sh[15:0]} :
            (funct3 == LW || funct3 == LWU) ? {{32{sx & sh[31]}}, sh[31:0]} :
            funct3 == LD ? sh : 64'd0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit sync RAM between fetch and load/store, MEM priority with bounded IF starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [31:0]       ifRdata,
  output logic              ifValid,
  output logic              ifErr,
  output logic              ifStall,
  input  logic              memReq,
  input  logic              memWe,
  input  logic [2:0]        memFunct3,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [63:0]       memWdata,
  output logic [63:0]       memRdata,
  output logic              memValid,
  output logic              memErr,
  output logic              memStall,
  output logic              ramEn,
  output logic [7:0]        ramWe,
  output logic [ADDR_W-4:0] ramAddr,
  output logic [63:0]       ramWdata,
  input  logic [63:0]       ramRdata
);
  localparam int SW_W = $clog2(MAX_STREAK + 1);
  state_t          state, nxt;
  logic [2:0]      a_q, f3_q;
  logic            err_q, we_q;
  logic [SW_W-1:0] streak;
  logic            idle, gnt_mem, gnt_if, st_issue;
  logic [7:0]      al_we;
  logic [63:0]     al_wdata, al_ldata;
  logic            al_mis;
  assign idle     = state == IDLE && resetn;
  assign gnt_mem  = idle && memReq && !(ifReq && streak == SW_W'(MAX_STREAK));
  assign gnt_if   = idle && ifReq && !gnt_mem;
  assign st_issue = gnt_mem && memWe;
  mem_lane_align u_align (
    .funct3   (idle ? memFunct3 : f3_q),
    .addr     (idle ? memAddr[2:0] : a_q),
    .store    (idle ? memWe : we_q),
    .wdata    (memWdata),
    .rdata    (ramRdata),
    .we       (al_we),
    .wdata_rep(al_wdata),
    .ldata    (al_ldata),
    .mis      (al_mis)
  );
  assign ramEn    = gnt_mem || gnt_if;
  assign ramAddr  = gnt_mem ? memAddr[ADDR_W-1:3] : gnt_if ? ifAddr[ADDR_W-1:3] : '0;
  assign ramWe    = st_issue ? al_we : 8'h00;
  assign ramWdata = st_issue ? al_wdata : 64'd0;
  assign ifValid  = state == WAIT_IF;
  assign ifErr    = ifValid && err_q;
  assign ifRdata  = ifValid && !err_q ? (a_q[2] ? ramRdata[63:32] : ramRdata[31:0]) : 32'd0;
  assign memValid = state == WAIT_MEM;
  assign memErr   = memValid && err_q;
  assign memRdata = memValid && !we_q && !err_q ? al_ldata : 64'd0;
  assign ifStall  = resetn && ifReq && !ifValid;
  assign memStall = resetn && memReq && !memValid;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  // every access is one issue cycle followed by one completion cycle
  always_comb begin
    nxt = gnt_mem ? WAIT_MEM : gnt_if ? WAIT_IF : IDLE;
  end
  // capture lane, funct3 and error of the granted access; track MEM grants while IF waits
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      a_q    <= '0;
      f3_q   <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      streak <= '0;
    end else begin
      if (ramEn) begin
        a_q   <= gnt_mem ? memAddr[2:0] : ifAddr[2:0];
        f3_q  <= memFunct3;
        we_q  <= st_issue;
        err_q <= gnt_mem ? al_mis : |ifAddr[1:0];
      end
      if (!ifReq || gnt_if) streak <= '0;
      else if (gnt_mem && streak != SW_W'(MAX_STREAK)) streak <= streak + 1'b1;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 64-bit synchronous block RAM between two requesters: the IF stage (instruction fetch) and the MEM stage (loads and stores).
- Handles byte-lane alignment, load sign/zero extension and store byte enables.
- Generates stall requests that the pipeline combines with the control unit's pcStall/ifidStall.
- Gives MEM priority, with a bounded-starvation guarantee for IF.

Parameters:
- ADDR_W, 16, byte-address width of both requesters.
- MAX_STREAK, 4, maximum consecutive MEM grants while IF is waiting.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset. Asynchronous, active-low.
- ifReq  in  1  fetch request, held until ifValid.
- ifAddr  in  ADDR_W  fetch byte address.
- ifRdata  out  32  fetched instruction.
- ifValid  out  1  fetch complete (1-cycle pulse).
- ifErr  out  1  misaligned fetch, qualified by ifValid.
- ifStall  out  1  ifReq && !ifValid.
- memReq  in  1  data request, held until memValid.
- memWe  in  1  1 = store, 0 = load.
- memFunct3  in  3  RV64 load/store funct3.
- memAddr  in  ADDR_W  data byte address.
- memWdata  in  64  store data, right-aligned.
- memRdata  out  64  extended load result.
- memValid  out  1  data access complete (1-cycle pulse).
- memErr  out  1  misaligned access, qualified by memValid.
- memStall  out  1  memReq && !memValid.
- ramEn  out  1  RAM enable.
- ramWe  out  8  RAM byte write enables.
- ramAddr  out  ADDR_W-3  RAM doubleword address.
- ramWdata  out  64  RAM write data.
- ramRdata  in  64  RAM read data, valid 1 cycle after ramEn.

Behaviour:
- States: IDLE, WAIT_IF, WAIT_MEM (2 bits). Every access takes exactly 2 cycles: issue, then complete. There is no back-to-back issue.
- Reset (async, resetn=0):
  - State goes to IDLE and streak counter to 0.
  - Every output is 0: ifRdata, memRdata, valids, errs, stalls (stall ignores req during reset), ramEn, ramWe, ramAddr, ramWdata.
  - An access in flight is dropped. The requester still holds req and is re-served after reset releases.
- IDLE, arbitration:
  - Both requests high: winner is MEM unless streak==MAX_STREAK, then IF.
  - Only one request high: that requester wins.
  - The winner's address drives ramAddr = addr[ADDR_W-1:3] and ramEn=1 in the same cycle.
  - The arbiter registers addr[2:0], funct3 and the error flag, then moves to WAIT_IF or WAIT_MEM.
  - No request: ramEn=0 and state stays IDLE.
- Streak counter:
  - Increments on each MEM grant while ifReq=1, saturating at MAX_STREAK.
  - Clears on an IF grant or any cycle with ifReq=0.
- WAIT_x:
  - Asserts xValid for one cycle and returns to IDLE.
  - The other requester's stall stays high.
  - If req drops in WAIT, valid still pulses and the result is discarded by the requester.
- Fetch path:
  - ifAddr[1:0]!=0 gives ifErr=1 and ifRdata=0. The RAM is still read; it is harmless.
  - ifRdata = ramRdata half selected by the latched addr[2] (1 = upper 32 bits).
- Load path (funct3):
  - LB=000, LH=001, LW=010, LD=011 are sign-extended.
  - LBU=100, LHU=101, LWU=110 are zero-extended.
  - The lane is selected by latched addr[2:0].
  - funct3=111 is treated as misaligned.
- Store path (funct3):
  - SB=000, SH=001, SW=010, SD=011.
  - ramWdata = memWdata replicated into the addressed lane.
  - ramWe = size mask shifted left by addr[2:0]. The write occurs at the issue edge.
  - WAIT_MEM returns memValid with memRdata=0.
- Alignment:
  - Misaligned means the address is not a multiple of the access size, or funct3 is invalid.
  - A misaligned store issues with ramWe=0 (no write) and memErr=1 in WAIT_MEM.
  - A misaligned load returns memRdata=0 with memErr=1.
- ramWe is nonzero only in IDLE issue cycles for a MEM store. ramEn is 0 in WAIT states.

Decomposition:
- Shared package holds:
  - Load/store funct3 constants: LB..LWU, SB..SD.
  - State encodings: IDLE=0, WAIT_IF=1, WAIT_MEM=2.
  - Size-mask function.
- One sub-module, mem_lane_align, is purely combinational. It takes funct3, addr[2:0], store data and ramRdata, and produces ramWe, ramWdata, the extended load data and the misaligned flag.

Test Plan:
1. Reset, fetch path:
   - Stimulus: reset, then ifReq=1 with ifAddr=0x0004 and RAM dword 0 = 0x11223344_AABBCCDD.
   - Required: ramEn=1 in cycle 1; ifValid=1 with ifRdata=0x11223344 in cycle 2; ifStall=1 only in cycle 1.
2. Contention and starvation bound:
   - Stimulus: ifReq and memReq held high continuously, with memReq re-asserted after each grant.
   - Required grant order: MEM×4, then IF, then MEM×4, and so on. ifValid never waits more than 10 cycles.
3. Store then load, with extension:
   - SB 0xFF to address 0x0013: ramWe=0x08, ramWdata lane 3 = 0xFF.
   - Then LB from 0x0013: memRdata=0xFFFFFFFF_FFFFFFFF.
   - Then LBU from 0x0013: memRdata=0x00000000_000000FF.
4. Misaligned accesses:
   - SW to 0x0006: ramWe=0, memErr=1, RAM unchanged.
   - LD from 0x0004: memErr=1, memRdata=0.
   - ifAddr=0x0002: ifErr=1.
5. Reset mid-access:
   - Stimulus: pull resetn low in the WAIT_MEM cycle of a load.
   - Required: memValid=0 immediately and state IDLE. After release with memReq still high, the load is re-issued and completes 2 cycles later with correct data.
6. Request withdrawn:
   - Stimulus: ifReq drops during WAIT_IF.
   - Required: ifValid still pulses once; next cycle IDLE with ramEn=0 and no spurious grant.
